alu_serial_sequencer: RTL and testbench
=======================================

# alu_serial_sequencer

Bit-serial operand sequencer that sits directly upstream of the 1-bit ALU slice and also consumes its output. It accepts a WIDTH-bit operation request, presents one bit pair per cycle (LSB first) to the slice with a registered carry chain, and shifts the slice result back into a WIDTH-bit result register. On completion it flags done, carry, zero and error.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2–32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only while busy=0.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- alu_op  input  4  operation code; captured on an accepted start.
- busy  output  1  high while bits are being sequenced.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  final result; held until the next accepted start.
- carry_out  output  1  final carry (ADD/SUB); 0 for logic ops.
- zero  output  1  result == 0; valid with done and held.
- error  output  1  unsupported alu_op on the last request; held.
- overflow  output  1  signed overflow (see Configuration).
- slice_a, slice_b, slice_cin  output  1  bit pair and carry-in to the slice.
- slice_op  output  4  op code to the slice.
- slice_result, slice_cout  input  1  slice outputs; combinational, sampled in the same cycle.

## Operation
- Supported ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
- Slice contract for 0010: slice_result = a^b^cin, slice_cout = majority(a,b,cin).
- SUB: the sequencer drives the slice with op 0010, slice_b = ~b[i], and initial carry 1. carry_out = 1 means no borrow.
- ADD: initial carry 0.
- Logic ops: the internal carry is forced to 0 and carry_out = 0.
- FSM:
  - IDLE: start=1 with a legal op → SHIFT; captures a, b and op, clears bit index and result shift register. start=1 with an illegal op → DONE with error=1, result=0, carry_out=0, zero=1.
  - SHIFT: drives bit index i; registers slice_result into result[i] and slice_cout into the carry. After i = WIDTH-1 → DONE.
  - DONE: done=1 for one cycle, then → IDLE.
- start is ignored during SHIFT and DONE; no queueing.
- slice_* outputs are 0 outside SHIFT.
- Reset at any point: state IDLE; busy, done, result, carry_out, zero, error, overflow and internal carry all 0. Any in-flight operation is discarded.

## Timing
- Accepted start in cycle T (legal op):
  - busy=1 in cycles T+1 through T+WIDTH.
  - Bit i is presented in cycle T+1+i.
  - done=1 in cycle T+WIDTH+1, with result, carry_out, zero and overflow valid from that cycle onward.
- Illegal op: done=1 in cycle T+1; busy never asserts.
- A new start is accepted no earlier than the done cycle + 1 (the IDLE cycle). Throughput is one op per WIDTH+2 cycles.
- The output result does not change during SHIFT; it updates atomically when DONE is entered.

## Configuration
- ALU_SEQ_OVERFLOW_EN defined: overflow = carry into MSB XOR carry out of MSB, computed for ADD/SUB at the final bit. It is 0 for logic ops and illegal ops, is valid with done, and is held.
- ALU_SEQ_OVERFLOW_EN undefined: the overflow port exists but is tied to 0, and no MSB-carry register is built.

## Test plan
- WIDTH=8, AND 0x5A & 0x0F → done at T+9, result=0x0A, carry_out=0, zero=0, error=0.
- ADD 200+100 → result=0x2C, carry_out=1, overflow=0. ADD 0x7F+0x01 → result=0x80, carry_out=0, overflow=1 (macro defined) / 0 (undefined).
- SUB 5−7 → result=0xFE, carry_out=0; SUB 7−7 → result=0x00, carry_out=1, zero=1.
- alu_op=0011 → done at T+1, error=1, result=0, busy stays 0. A following legal op clears error.
- start pulsed during SHIFT with different operands → ignored, original result delivered. rst_n low mid-SHIFT → all outputs 0 immediately, FSM in IDLE, next start completes normally.
- NOR 0xF0, 0x0C → 0x03. Check slice_a/slice_b bit order LSB-first on cycles T+1..T+8 and slice_* = 0 when idle.

Source files
------------

// File: rtl/alu_serial_sequencer_if.sv
// Request/response bundle between an operation requester and alu_serial_sequencer.
// The sequencer uses the slave modport; the requester uses master.
interface alu_serial_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;
    logic             error;
    logic             overflow;

    modport master (
        output start, a, b, alu_op,
        input  busy, done, result, carry_out, zero, error, overflow
    );

    modport slave (
        input  start, a, b, alu_op,
        output busy, done, result, carry_out, zero, error, overflow
    );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Bit-serial operand sequencer driving an external 1-bit ALU slice, LSB first.
// Define ALU_SEQ_OVERFLOW_EN to build the signed-overflow flag; otherwise overflow is tied to 0.
module alu_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_serial_sequencer_if.slave req,
    output logic                  slice_a,
    output logic                  slice_b,
    output logic                  slice_cin,
    output logic [3:0]            slice_op,
    input  logic                  slice_result,
    input  logic                  slice_cout
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_arith(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB: op_arith = 1'b1;
            default:        op_arith = 1'b0;
        endcase
    endfunction

    state_e           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [3:0]       slice_op_q;
    logic             arith_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             zero_q;
    logic             error_q;

    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             last_bit_d;
    logic             accept_legal_d;
    logic             accept_illegal_d;

    // Next result/carry values from the slice, and start acceptance decode
    always_comb begin
        res_d            = {slice_result, res_sh_q[WIDTH-1:1]};
        carry_d          = arith_q ? slice_cout : 1'b0;
        last_bit_d       = (idx_q == IW'(WIDTH - 1));
        accept_legal_d   = 1'b0;
        accept_illegal_d = 1'b0;
        if (state_q == ST_IDLE && req.start) begin
            accept_legal_d   = op_legal(req.alu_op);
            accept_illegal_d = !op_legal(req.alu_op);
        end else begin
            accept_legal_d   = 1'b0;
            accept_illegal_d = 1'b0;
        end
    end

    // Sequencer FSM: operand shift registers shift right so bit 0 always feeds the slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            slice_op_q  <= 4'b0000;
            arith_q     <= 1'b0;
            carry_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept_legal_d) begin
                        state_q    <= ST_SHIFT;
                        busy_q     <= 1'b1;
                        idx_q      <= '0;
                        res_sh_q   <= '0;
                        a_sh_q     <= req.a;
                        // SUB runs as A + ~B + 1 on the adder slice
                        b_sh_q     <= (req.alu_op == OP_SUB) ? ~req.b : req.b;
                        slice_op_q <= (req.alu_op == OP_SUB) ? OP_ADD : req.alu_op;
                        arith_q    <= op_arith(req.alu_op);
                        carry_q    <= (req.alu_op == OP_SUB);
                    end else if (accept_illegal_d) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        result_q    <= '0;
                        carry_out_q <= 1'b0;
                        zero_q      <= 1'b1;
                        error_q     <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    res_sh_q <= res_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    idx_q    <= idx_q + IW'(1);
                    if (last_bit_d) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_q    <= res_d;
                        zero_q      <= (res_d == '0);
                        carry_out_q <= carry_d;
                        error_q     <= 1'b0;
                        a_sh_q      <= '0;
                        b_sh_q      <= '0;
                        slice_op_q  <= 4'b0000;
                        arith_q     <= 1'b0;
                        carry_q     <= 1'b0;
                    end else begin
                        carry_q <= carry_d;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    a_sh_q     <= '0;
                    b_sh_q     <= '0;
                    slice_op_q <= 4'b0000;
                    arith_q    <= 1'b0;
                    carry_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    logic overflow_q;

    // Carry into the MSB is the registered carry presented on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (state_q == ST_SHIFT && last_bit_d) begin
            overflow_q <= arith_q & (carry_q ^ slice_cout);
        end else if (accept_illegal_d) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_q;
        end
    end

    assign req.overflow = overflow_q;
`else
    assign req.overflow = 1'b0;
`endif

    assign req.busy      = busy_q;
    assign req.done      = done_q;
    assign req.result    = result_q;
    assign req.carry_out = carry_out_q;
    assign req.zero      = zero_q;
    assign req.error     = error_q;

    assign slice_a   = a_sh_q[0];
    assign slice_b   = b_sh_q[0];
    assign slice_cin = carry_q;
    assign slice_op  = slice_op_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer (WIDTH=8) with a behavioural 1-bit ALU slice.
module tb_alu_serial_sequencer;

    localparam int W = 8;
`ifdef ALU_SEQ_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] res;
        logic       cout;
        logic       zero;
        logic       err;
        logic       ovf;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       slice_a, slice_b, slice_cin;
    logic [3:0] slice_op;
    logic       slice_result, slice_cout;

    alu_serial_sequencer_if #(.WIDTH(W)) bus ();

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (bus),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_op     (slice_op),
        .slice_result (slice_result),
        .slice_cout   (slice_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the 1-bit ALU slice
    always_comb begin
        slice_result = 1'b0;
        slice_cout   = 1'b0;
        case (slice_op)
            4'b0000: slice_result = slice_a & slice_b;
            4'b0001: slice_result = slice_a | slice_b;
            4'b0010: begin
                slice_result = slice_a ^ slice_b ^ slice_cin;
                slice_cout   = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
            end
            4'b1100: slice_result = ~(slice_a | slice_b);
            default: slice_result = 1'b0;
        endcase
    end

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[12];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int glitch);
        vec_t       e;
        logic [7:0] sa, sb, exp_b;
        int         nbusy, lat, g;
        bit         got;
        sa = 8'h00; sb = 8'h00; nbusy = 0; lat = 0; got = 1'b0; g = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && g < 50) begin
            @(negedge clk);
            g++;
        end
        exp_q.push_back(v);
        bus.a = v.a; bus.b = v.b; bus.alu_op = v.op; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= W + 4; k++) begin
            if (glitch == k) begin
                bus.start = 1'b1; bus.a = ~v.a; bus.b = 8'h33; bus.alu_op = 4'b0010;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) begin
                if (nbusy < W) begin
                    sa[nbusy] = slice_a;
                    sb[nbusy] = slice_b;
                end
                nbusy++;
            end
            if (bus.done) begin
                got = 1'b1;
                lat = k;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", W + 4);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        check("done_latency", lat, (e.err ? 1 : W + 1));
        check("busy_cycles", nbusy, (e.err ? 0 : W));
        check("result", bus.result, e.res);
        check("carry_out", bus.carry_out, e.cout);
        check("zero", bus.zero, e.zero);
        check("error", bus.error, e.err);
        check("overflow", bus.overflow, (OVF_EN ? e.ovf : 1'b0));
        if (!e.err) begin
            exp_b = (e.op == 4'b0110) ? ~e.b : e.b;
            check("slice_a_bits", sa, e.a);
            check("slice_b_bits", sb, exp_b);
        end
        @(negedge clk);
        check("done_one_cycle", bus.done, 1'b0);
        check("slice_idle", {slice_a, slice_b, slice_cin, slice_op}, 7'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            a      b      op       res    co    z     err   ovf
        vecs[0]  = '{8'h5A, 8'h0F, 4'b0000, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'hC8, 8'h64, 4'b0010, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h7F, 8'h01, 4'b0010, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{8'h05, 8'h07, 4'b0110, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h07, 8'h07, 4'b0110, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'h12, 8'h34, 4'b0011, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{8'hF0, 8'h0C, 4'b1100, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 4'b0001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'h80, 8'h01, 4'b0110, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{8'hFF, 8'h01, 4'b0010, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{8'hAA, 8'h55, 4'b1111, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{8'hA5, 8'h3C, 4'b0001, 8'hBD, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.alu_op = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.busy, bus.done, bus.result, bus.carry_out,
                                bus.zero, bus.error, bus.overflow}, 14'd0);
        check("reset_slice", {slice_a, slice_b, slice_cin, slice_op}, 7'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], 0);
        end

        // start pulsed mid-SHIFT with other operands must be ignored
        run_op(vecs[6], 3);
        run_op(vecs[1], W);

        // reset in the middle of an ADD that is propagating a carry
        run_op(vecs[2], 0);
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'h01; bus.alu_op = 4'b0010; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before_reset", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {bus.busy, bus.done, bus.result, bus.carry_out,
                                    bus.zero, bus.error, bus.overflow}, 14'd0);
        check("mid_reset_slice", {slice_a, slice_b, slice_cin, slice_op}, 7'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(vecs[4], 0);
        run_op(vecs[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
